// File: rtl/pwr_domain_seq_if.sv
// AXI-lite register-port bundle for the power-domain sequencer.
// The master drives valids, addresses, write data and response readies.
interface pwr_domain_seq_if;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  modport master (
    output aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, w_valid, w_data, b_ready, ar_valid, ar_addr, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/pwr_domain_seq.sv
// Power-domain sequencer: one shared FSM walks a single domain through
// isolate/reset/clock/power steps on AXI-lite CMD writes, with ack timeout.
module pwr_domain_seq #(
  parameter int unsigned NUM_DOM     = 8,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  pwr_domain_seq_if.slave    bus,
  output logic [NUM_DOM-1:0] pwr_en_o,
  input  logic [NUM_DOM-1:0] pwr_ack_i,
  output logic [NUM_DOM-1:0] iso_o,
  output logic [NUM_DOM-1:0] dom_rst_no,
  output logic [NUM_DOM-1:0] clk_en_o
);

  localparam int unsigned CNT_W = 32;
  localparam logic [1:0]  RESP_OK  = 2'd0;
  localparam logic [1:0]  RESP_ERR = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_ISO, S_RST, S_CLKOFF, S_PWROFF, S_WAIT_OFF, S_PWRON,
    S_WAIT_ON, S_SETTLE, S_CLKON, S_RSTREL, S_ISOREL, S_RESP
  } state_t;

  state_t             state;
  logic [NUM_DOM-1:0] cur_mask;
  logic [NUM_DOM-1:0] fault;
  logic [CNT_W-1:0]   cnt;

  logic [3:0]         wr_dom, rd_dom;
  logic [NUM_DOM-1:0] wr_mask, rd_mask;
  logic [2:0]         wr_cmd;
  logic               wr_ok, wr_is_on, wr_dom_on;
  logic               rd_in, rd_on, rd_busy, rd_fault;
  logic               idle_free, wr_go, rd_go, ack_sel;
  logic               unused_bits;

  // Address/command decode; a domain counts as on while its switch is enabled
  assign wr_dom    = bus.aw_addr[7:4];
  assign rd_dom    = bus.ar_addr[7:4];
  assign wr_mask   = NUM_DOM'(1) << wr_dom;
  assign rd_mask   = NUM_DOM'(1) << rd_dom;
  assign wr_cmd    = bus.w_data[2:0];
  assign wr_is_on  = (wr_cmd == 3'd4);
  assign wr_ok     = (32'(wr_dom) < NUM_DOM) && (bus.aw_addr[3:0] == 4'h4)
                     && ((wr_cmd == 3'd3) || (wr_cmd == 3'd4));
  assign wr_dom_on = |(pwr_en_o & wr_mask);
  assign rd_in     = (32'(rd_dom) < NUM_DOM);
  assign rd_on     = |(pwr_en_o & rd_mask);
  assign rd_fault  = |(fault & rd_mask);
  assign rd_busy   = (state != S_IDLE) && (state != S_RESP) && |(cur_mask & rd_mask);
  assign ack_sel   = |(pwr_ack_i & cur_mask);

  // Only one transaction in flight: no new accept while a ready pulse or response is out
  assign idle_free = (state == S_IDLE) && !bus.b_valid && !bus.r_valid
                     && !bus.aw_ready && !bus.ar_ready;
  assign wr_go     = idle_free && bus.aw_valid && bus.w_valid;
  assign rd_go     = idle_free && bus.ar_valid && !(bus.aw_valid && bus.w_valid);

  assign unused_bits = ^{bus.aw_addr[31:8], bus.ar_addr[31:8], bus.w_data[31:3]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cur_mask     <= '0;
      fault        <= '0;
      cnt          <= '0;
      pwr_en_o     <= '1;
      iso_o        <= '0;
      dom_rst_no   <= '1;
      clk_en_o     <= '1;
      bus.aw_ready <= 1'b0;
      bus.w_ready  <= 1'b0;
      bus.b_valid  <= 1'b0;
      bus.b_resp   <= 2'd0;
      bus.ar_ready <= 1'b0;
      bus.r_valid  <= 1'b0;
      bus.r_resp   <= 2'd0;
      bus.r_data   <= 32'd0;
    end else begin
      bus.aw_ready <= wr_go;
      bus.w_ready  <= wr_go;
      bus.ar_ready <= rd_go;

      // Read channel: response the cycle after ar_ready, held until r_ready
      if (bus.ar_ready && bus.ar_valid) begin
        bus.r_valid <= 1'b1;
        if (rd_in && bus.ar_addr[3:0] == 4'h0) begin
          bus.r_data <= {29'd0, rd_fault, rd_busy, rd_on};
          bus.r_resp <= RESP_OK;
        end else if (rd_in && bus.ar_addr[3:0] == 4'h4) begin
          bus.r_data <= rd_on ? 32'd4 : 32'd3;
          bus.r_resp <= RESP_OK;
        end else begin
          bus.r_data <= 32'd0;
          bus.r_resp <= RESP_ERR;
        end
      end else if (bus.r_valid && bus.r_ready) begin
        bus.r_valid <= 1'b0;
      end

      // Each output step is applied on the edge that enters the named state
      case (state)
        S_IDLE: begin
          if (bus.aw_ready && bus.aw_valid) begin
            cur_mask <= wr_mask;
            cnt      <= '0;
            if (!wr_ok) begin
              state       <= S_RESP;
              bus.b_valid <= 1'b1;
              bus.b_resp  <= RESP_ERR;
            end else if (wr_is_on == wr_dom_on) begin
              state       <= S_RESP;
              bus.b_valid <= 1'b1;
              bus.b_resp  <= RESP_OK;
              fault       <= fault & ~wr_mask;
            end else if (wr_is_on) begin
              state    <= S_PWRON;
              pwr_en_o <= pwr_en_o | wr_mask;
            end else begin
              state <= S_ISO;
              iso_o <= iso_o | wr_mask;
            end
          end
        end
        S_ISO: begin
          state      <= S_RST;
          dom_rst_no <= dom_rst_no & ~cur_mask;
        end
        S_RST: begin
          state    <= S_CLKOFF;
          clk_en_o <= clk_en_o & ~cur_mask;
        end
        S_CLKOFF: begin
          state    <= S_PWROFF;
          pwr_en_o <= pwr_en_o & ~cur_mask;
        end
        S_PWROFF: begin
          state <= S_WAIT_OFF;
          cnt   <= '0;
        end
        S_WAIT_OFF: begin
          if (!ack_sel) begin
            state       <= S_RESP;
            bus.b_valid <= 1'b1;
            bus.b_resp  <= RESP_OK;
            fault       <= fault & ~cur_mask;
          end else if (cnt + 32'd1 >= TIMEOUT_CYC) begin
            state       <= S_RESP;
            bus.b_valid <= 1'b1;
            bus.b_resp  <= RESP_ERR;
            fault       <= fault | cur_mask;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_PWRON: begin
          state <= S_WAIT_ON;
          cnt   <= '0;
        end
        S_WAIT_ON: begin
          if (ack_sel) begin
            state <= S_SETTLE;
            cnt   <= '0;
          end else if (cnt + 32'd1 >= TIMEOUT_CYC) begin
            state       <= S_RESP;
            bus.b_valid <= 1'b1;
            bus.b_resp  <= RESP_ERR;
            fault       <= fault | cur_mask;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          if (cnt + 32'd1 >= SETTLE_CYC) begin
            state    <= S_CLKON;
            clk_en_o <= clk_en_o | cur_mask;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_CLKON: begin
          state      <= S_RSTREL;
          dom_rst_no <= dom_rst_no | cur_mask;
        end
        S_RSTREL: begin
          state <= S_ISOREL;
          iso_o <= iso_o & ~cur_mask;
        end
        S_ISOREL: begin
          state       <= S_RESP;
          bus.b_valid <= 1'b1;
          bus.b_resp  <= RESP_OK;
          fault       <= fault & ~cur_mask;
        end
        S_RESP: begin
          if (bus.b_ready) begin
            state       <= S_IDLE;
            bus.b_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwr_domain_seq.sv
// Directed bench for pwr_domain_seq: OFF/ON sequencing timing, no-op and
// error writes, ack timeout with fault recovery, channel priority, mid-sequence reset.
module tb_pwr_domain_seq;
  localparam int unsigned NUM_DOM     = 8;
  localparam int unsigned SETTLE_CYC  = 4;
  localparam int unsigned TIMEOUT_CYC = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pwr_en, pwr_ack, iso, dom_rst_n, clk_en;
  int unsigned ntot = 0, npass = 0, nfail = 0;

  pwr_domain_seq_if bus();

  pwr_domain_seq #(
    .NUM_DOM(NUM_DOM), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pwr_en_o   (pwr_en),
    .pwr_ack_i  (pwr_ack),
    .iso_o      (iso),
    .dom_rst_no (dom_rst_n),
    .clk_en_o   (clk_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] p, input logic [7:0] i,
                      input logic [7:0] r, input logic [7:0] c);
    chk({tag, ".pwr_en"}, 32'(pwr_en), 32'(p));
    chk({tag, ".iso"},    32'(iso),    32'(i));
    chk({tag, ".rst_n"},  32'(dom_rst_n), 32'(r));
    chk({tag, ".clk_en"}, 32'(clk_en), 32'(c));
  endtask

  // Returns in the cycle after the AW/W handshake, valids already dropped
  task automatic wr_accept(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    bus.aw_addr  = a;
    bus.w_data   = d;
    bus.aw_valid = 1'b1;
    bus.w_valid  = 1'b1;
    while (!bus.aw_ready && n < 20) begin tick(); n++; end
    chk("aw_ready", 32'(bus.aw_ready), 32'd1);
    chk("w_ready",  32'(bus.w_ready),  32'd1);
    tick();
    bus.aw_valid = 1'b0;
    bus.w_valid  = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [1:0] resp);
    int n = 0;
    bus.b_ready = 1'b1;
    while (!bus.b_valid && n < 64) begin tick(); n++; end
    chk({tag, ".b_valid"}, 32'(bus.b_valid), 32'd1);
    chk({tag, ".b_resp"},  32'(bus.b_resp),  32'(resp));
    tick();
    bus.b_ready = 1'b0;
    chk({tag, ".b_done"}, 32'(bus.b_valid), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] resp);
    int n = 0;
    bus.ar_addr  = a;
    bus.ar_valid = 1'b1;
    while (!bus.ar_ready && n < 20) begin tick(); n++; end
    chk({tag, ".ar_ready"}, 32'(bus.ar_ready), 32'd1);
    tick();
    bus.ar_valid = 1'b0;
    chk({tag, ".r_valid"}, 32'(bus.r_valid), 32'd1);
    chk({tag, ".r_data"},  bus.r_data,       d);
    chk({tag, ".r_resp"},  32'(bus.r_resp),  32'(resp));
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    chk({tag, ".r_done"}, 32'(bus.r_valid), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    pwr_ack = 8'hFF;
    bus.aw_valid = 1'b0; bus.aw_addr = 32'd0; bus.w_valid = 1'b0; bus.w_data = 32'd0;
    bus.b_ready = 1'b0; bus.ar_valid = 1'b0; bus.ar_addr = 32'd0; bus.r_ready = 1'b0;
    repeat (2) tick();
    outs("reset", 8'hFF, 8'h00, 8'hFF, 8'hFF);
    chk("reset.aw_ready", 32'(bus.aw_ready), 32'd0);
    chk("reset.b_valid",  32'(bus.b_valid),  32'd0);
    chk("reset.r_valid",  32'(bus.r_valid),  32'd0);
    rst_n = 1'b1;
    tick();

    // OFF domain 2: one step per cycle, ack drops at T+6, B at T+7
    wr_accept(32'h24, 32'd3);
    outs("off.t1", 8'hFF, 8'h04, 8'hFF, 8'hFF); tick();
    outs("off.t2", 8'hFF, 8'h04, 8'hFB, 8'hFF); tick();
    outs("off.t3", 8'hFF, 8'h04, 8'hFB, 8'hFB); tick();
    outs("off.t4", 8'hFB, 8'h04, 8'hFB, 8'hFB); tick();
    chk("off.t5.b_valid", 32'(bus.b_valid), 32'd0); tick();
    pwr_ack = 8'hFB;
    chk("off.t6.b_valid", 32'(bus.b_valid), 32'd0); tick();
    chk("off.t7.b_valid", 32'(bus.b_valid), 32'd1);
    wait_b("off", 2'd0);
    rd("st2_off", 32'h20, 32'd0, 2'd0);
    rd("cmd2_off", 32'h24, 32'd3, 2'd0);

    // ON domain 2: ack three cycles after pwr_en, four settle cycles
    wr_accept(32'h24, 32'd4);
    outs("on.p0", 8'hFF, 8'h04, 8'hFB, 8'hFB);
    tick(); tick(); tick();
    pwr_ack = 8'hFF;
    repeat (4) tick();
    outs("on.p7", 8'hFF, 8'h04, 8'hFB, 8'hFB); tick();
    outs("on.p8", 8'hFF, 8'h04, 8'hFB, 8'hFF); tick();
    outs("on.p9", 8'hFF, 8'h04, 8'hFF, 8'hFF); tick();
    outs("on.p10", 8'hFF, 8'h00, 8'hFF, 8'hFF);
    chk("on.p10.b_valid", 32'(bus.b_valid), 32'd0); tick();
    chk("on.p11.b_valid", 32'(bus.b_valid), 32'd1);
    wait_b("on", 2'd0);
    rd("st2_on", 32'h20, 32'd1, 2'd0);
    rd("cmd2_on", 32'h24, 32'd4, 2'd0);

    // ON to an already-on domain: immediate OKAY, nothing moves
    wr_accept(32'h14, 32'd4);
    chk("noop.b_valid", 32'(bus.b_valid), 32'd1);
    outs("noop", 8'hFF, 8'h00, 8'hFF, 8'hFF);
    wait_b("noop", 2'd0);

    // Error writes and unmapped reads
    wr_accept(32'h94, 32'd3);
    chk("oor.b_valid", 32'(bus.b_valid), 32'd1);
    wait_b("oor", 2'd2);
    wr_accept(32'h24, 32'd5);
    wait_b("baddata", 2'd2);
    wr_accept(32'h20, 32'd3);
    wait_b("status_wr", 2'd2);
    outs("err", 8'hFF, 8'h00, 8'hFF, 8'hFF);
    rd("rd_oor", 32'h98, 32'd0, 2'd2);
    rd("rd_off", 32'h2C, 32'd0, 2'd2);

    // OFF domain 3 with ack stuck high: TIMEOUT_CYC wait cycles then SLVERR
    wr_accept(32'h34, 32'd3);
    repeat (TIMEOUT_CYC + 3) tick();
    chk("to.early", 32'(bus.b_valid), 32'd0); tick();
    chk("to.b_valid", 32'(bus.b_valid), 32'd1);
    wait_b("to", 2'd2);
    outs("to", 8'hF7, 8'h08, 8'hF7, 8'hF7);
    rd("st3_fault", 32'h30, 32'd4, 2'd0);
    rd("cmd3_fault", 32'h34, 32'd3, 2'd0);
    wr_accept(32'h34, 32'd4);
    wait_b("recover", 2'd0);
    outs("recover", 8'hFF, 8'h00, 8'hFF, 8'hFF);
    rd("st3_ok", 32'h30, 32'd1, 2'd0);

    // Write wins over a simultaneous read; read waits for the B handshake
    bus.aw_addr = 32'h54; bus.w_data = 32'd4; bus.ar_addr = 32'h54;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1; bus.ar_valid = 1'b1;
    n = 0;
    while (!bus.aw_ready && n < 20) begin tick(); n++; end
    chk("prio.aw_ready", 32'(bus.aw_ready), 32'd1);
    chk("prio.ar_ready0", 32'(bus.ar_ready), 32'd0);
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    chk("prio.ar_ready1", 32'(bus.ar_ready), 32'd0);
    chk("prio.b_valid", 32'(bus.b_valid), 32'd1);
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    chk("prio.ar_ready2", 32'(bus.ar_ready), 32'd0);
    chk("prio.r_valid0", 32'(bus.r_valid), 32'd0);
    n = 0;
    while (!bus.ar_ready && n < 20) begin tick(); n++; end
    chk("prio.ar_ready", 32'(bus.ar_ready), 32'd1);
    tick();
    bus.ar_valid = 1'b0;
    chk("prio.r_valid", 32'(bus.r_valid), 32'd1);
    chk("prio.r_data", bus.r_data, 32'd4);
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;

    // Reset while domain 6 waits for its ack in WAIT_ON
    wr_accept(32'h64, 32'd3);
    pwr_ack = 8'hBF;
    wait_b("off6", 2'd0);
    outs("off6", 8'hBF, 8'h40, 8'hBF, 8'hBF);
    wr_accept(32'h64, 32'd4);
    tick(); tick(); tick();
    chk("on6.pwr_en", 32'(pwr_en), 32'hFF);
    chk("on6.b_valid", 32'(bus.b_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    outs("rst_mid", 8'hFF, 8'h00, 8'hFF, 8'hFF);
    chk("rst_mid.b_valid", 32'(bus.b_valid), 32'd0);
    pwr_ack = 8'hFF;
    tick();
    rst_n = 1'b1;
    tick();
    rd("st6_after_rst", 32'h60, 32'd1, 2'd0);
    rd("st3_after_rst", 32'h30, 32'd1, 2'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
